ram_partition_bist_master: RTL and testbench
============================================

Name: ram_partition_bist_master

Overview:
- Single-clock initiator that drives one port of the partitioned dual-port RAM through its native write/read interface.
- Fills a parameterised address window with a seeded pattern, waits for each write acknowledge, then reads the window back combinationally and checks it.
- Reports pass/fail, the mismatch count, the first failing address, and ack timeouts.
- Used for power-on self-test and by the bench as a traffic generator on either partition.

Parameters:
ADDR_W, 11, address width of the RAM port
DATA_W, 8, data width of the RAM port
BASE_ADDR, 0, first address tested (0 for port A partition, 1024 for port B)
DEPTH, 1024, number of consecutive locations tested (1..2048; BASE_ADDR+DEPTH <= 2048)
ACK_TIMEOUT, 15, max WAIT_ACK cycles before abort (>= 1)

Ports:
clk  in  1  clock; every RAM port signal is synchronous to it
reset  in  1  synchronous, active-high reset
start  in  1  start request, sampled only in IDLE
seed  in  DATA_W  pattern seed, captured when start is accepted
mem_wr_en  out  1  RAM write enable
mem_rd_en  out  1  RAM read enable
mem_addr  out  ADDR_W  RAM address
mem_data_out  out  DATA_W  RAM write data
mem_rd_data  in  DATA_W  RAM asynchronous read data
mem_wr_ack  in  1  RAM registered write acknowledge (arrives 1 cycle after the write edge)
busy  out  1  test in progress
done  out  1  one-cycle completion pulse
pass  out  1  last test had no mismatch and no timeout (held)
timeout  out  1  last test aborted on a missing ack (held)
err_count  out  12  mismatch count, saturating at 4095 (held)
first_err_addr  out  ADDR_W  first mismatching address, or the stalled write address on timeout; 0 if none (held)

Behaviour:
- Reset (synchronous): FSM goes to IDLE. mem_wr_en, mem_rd_en, mem_addr, mem_data_out, busy, done, pass, timeout, err_count and first_err_addr all read 0 on the cycle after reset is sampled high. Reset mid-test aborts immediately; no further RAM strobes are issued.
- Pattern: expected(a) = a[DATA_W-1:0] XOR seed_q. Address and data widths are truncated/zero-extended explicitly.
- States: IDLE, WRITE, WAIT_ACK, READ, DONE.
- IDLE:
  - Outputs: all strobes 0, busy=0.
  - On start=1: capture seed_q; set addr=BASE_ADDR; clear err_count, first_err_addr, pass and timeout; go to WRITE.
- WRITE (1 cycle):
  - Drive mem_wr_en=1, mem_addr=addr, mem_data_out=expected(addr).
  - Clear the timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - Drive mem_wr_en=0; mem_addr and mem_data_out hold.
  - mem_wr_ack=1 and addr is the last location: set addr=BASE_ADDR, go to READ.
  - mem_wr_ack=1 otherwise: addr+1, go to WRITE.
  - No ack: increment the counter. On ACK_TIMEOUT consecutive cycles without ack, set timeout=1 and first_err_addr=addr, then go to DONE.
  - Nominal cost with a zero-wait RAM is 2 cycles per write.
- READ (1 cycle per address):
  - Drive mem_rd_en=1, mem_addr=addr.
  - Sample mem_rd_data at the end of the same cycle (the RAM read path is combinational).
  - On mismatch: err_count+1 (saturating); if this is the first mismatch, capture first_err_addr=addr.
  - Last address: go to DONE; otherwise addr+1.
- DONE (1 cycle):
  - done=1, busy=0, strobes 0.
  - pass=1 iff err_count==0 and timeout==0. The mismatch of the final READ is included, since it is registered on the transition into DONE.
  - Return to IDLE.
- busy=1 exactly in WRITE, WAIT_ACK and READ. Nominal test: 3*DEPTH busy cycles, then done on the next cycle.
- start while busy or in DONE is ignored, with no queuing. A start held high in IDLE after DONE restarts the test.
- Result outputs hold until the next accepted start or reset.
- mem_wr_en and mem_rd_en are never asserted in the same cycle.
- Address never leaves [BASE_ADDR, BASE_ADDR+DEPTH-1]. No wrap-around past 2047.
- A wr_ack arriving outside WAIT_ACK is ignored.

Test Plan:
1. BASE_ADDR=0, DEPTH=1024, seed=0xA5, bench drives start one cycle against a RAM model on port A -> writes 0x005 get data 0xA0; busy 3072 cycles; done pulse; pass=1, err_count=0, first_err_addr=0.
2. Same configuration, but the model flips bit 0 of read data at addresses 0x010 and 0x200 -> err_count=2, first_err_addr=0x010, pass=0, timeout=0.
3. BASE_ADDR=1024, DEPTH=1024, seed=0x3C on port B -> first write at 0x400 with data 0x3C; pass=1; mem_addr never below 0x400.
4. Model suppresses mem_wr_ack for address 0x007 -> after 15 WAIT_ACK cycles: done=1, timeout=1, pass=0, first_err_addr=0x007; no READ strobes issued.
5. reset asserted during the READ of address 0x100 -> all outputs 0 the next cycle. A subsequent start runs a full clean test from BASE_ADDR with pass=1.
6. start pulsed repeatedly while busy -> exactly one done pulse. With start held high across DONE, a second test begins the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/ram_partition_bist_master.sv
// rtl/ram_partition_bist_master.sv - write/ack/read-back self-test master for one RAM partition
module ram_partition_bist_master #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH       = 1024,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_wr_ack,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [11:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT_ACK,
        S_READ,
        S_DONE
    } state_t;

    // Counter only needs to reach ACK_TIMEOUT-1; the cycle that would hit the limit aborts instead.
    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);
    localparam logic [TW-1:0]     TMO_LIMIT  = TW'(ACK_TIMEOUT - 1);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  seed_q;
    logic [TW-1:0]      ack_wait;
    logic [DATA_W-1:0]  expected;
    logic               at_last;
    logic               tmo_hit;
    logic               mismatch;
    logic [11:0]        err_inc;

    assign expected = DATA_W'(addr) ^ seed_q;
    assign at_last  = (addr == LAST_ADDR);
    assign tmo_hit  = (ack_wait == TMO_LIMIT);
    assign mismatch = (mem_rd_data != expected);
    assign err_inc  = (err_count == 12'hFFF) ? err_count : err_count + 12'd1;

    always_comb begin
        state_next   = state;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_addr     = '0;
        mem_data_out = '0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_next = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_en    = 1'b1;
                mem_addr     = addr;
                mem_data_out = expected;
                busy         = 1'b1;
                state_next   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                mem_addr     = addr;
                mem_data_out = expected;
                busy         = 1'b1;
                if (mem_wr_ack) state_next = at_last ? S_READ : S_WRITE;
                else if (tmo_hit) state_next = S_DONE;
            end
            S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr;
                busy      = 1'b1;
                if (at_last) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            addr           <= '0;
            seed_q         <= '0;
            ack_wait       <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_q         <= seed;
                        addr           <= FIRST_ADDR;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                    end
                end
                S_WRITE: ack_wait <= '0;
                S_WAIT_ACK: begin
                    if (mem_wr_ack) begin
                        addr <= at_last ? FIRST_ADDR : addr + ADDR_W'(1);
                    end else if (tmo_hit) begin
                        timeout        <= 1'b1;
                        first_err_addr <= addr;
                    end else begin
                        ack_wait <= ack_wait + TW'(1);
                    end
                end
                S_READ: begin
                    if (mismatch) begin
                        err_count <= err_inc;
                        if (err_count == 12'd0) first_err_addr <= addr;
                    end
                    // Final compare folds into pass on the same edge that enters DONE.
                    if (at_last) pass <= !mismatch && (err_count == 12'd0);
                    else addr <= addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_partition_bist_master.sv
// tb/tb_ram_partition_bist_master.sv - bench for ram_partition_bist_master on both RAM partitions
module tb_ram_partition_bist_master;

    localparam int DEPTH = 1024;
    localparam int LIMIT = 8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b;
    logic [7:0]  seed_a, seed_b;
    logic        wr_a, rd_a, wr_b, rd_b;
    logic [10:0] addr_a, addr_b;
    logic [7:0]  dout_a, dout_b, rdat_a, rdat_b;
    logic        ack_a, ack_b;
    logic        busy_a, done_a, pass_a, tmo_a;
    logic        busy_b, done_b, pass_b, tmo_b;
    logic [11:0] ec_a, ec_b;
    logic [10:0] fe_a, fe_b;

    ram_partition_bist_master #(.BASE_ADDR(0), .DEPTH(DEPTH)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .seed(seed_a),
        .mem_wr_en(wr_a), .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_data_out(dout_a),
        .mem_rd_data(rdat_a), .mem_wr_ack(ack_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .timeout(tmo_a), .err_count(ec_a), .first_err_addr(fe_a)
    );

    ram_partition_bist_master #(.BASE_ADDR(1024), .DEPTH(DEPTH)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .seed(seed_b),
        .mem_wr_en(wr_b), .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_data_out(dout_b),
        .mem_rd_data(rdat_b), .mem_wr_ack(ack_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .timeout(tmo_b), .err_count(ec_b), .first_err_addr(fe_b)
    );

    // Dual-port RAM model: registered ack, combinational read, optional fault knobs.
    logic [7:0]    mem [0:2047];
    logic [2047:0] flip_mask = '0;
    logic          supp_en = 1'b0;
    logic [10:0]   supp_addr = '0;

    always @(posedge clk) begin
        if (wr_a) mem[addr_a] <= dout_a;
        if (wr_b) mem[addr_b] <= dout_b;
        ack_a <= wr_a && !(supp_en && addr_a == supp_addr);
        ack_b <= wr_b && !(supp_en && addr_b == supp_addr);
    end
    assign rdat_a = mem[addr_a] ^ {7'b0, flip_mask[addr_a]};
    assign rdat_b = mem[addr_b] ^ {7'b0, flip_mask[addr_b]};

    int cur = 0;
    logic        s_wr, s_rd, s_busy, s_done, s_pass, s_tmo;
    logic [10:0] s_addr, s_fe;
    logic [7:0]  s_dout;
    logic [11:0] s_ec;
    assign s_wr   = (cur == 1) ? wr_b   : wr_a;
    assign s_rd   = (cur == 1) ? rd_b   : rd_a;
    assign s_busy = (cur == 1) ? busy_b : busy_a;
    assign s_done = (cur == 1) ? done_b : done_a;
    assign s_pass = (cur == 1) ? pass_b : pass_a;
    assign s_tmo  = (cur == 1) ? tmo_b  : tmo_a;
    assign s_addr = (cur == 1) ? addr_b : addr_a;
    assign s_dout = (cur == 1) ? dout_b : dout_a;
    assign s_ec   = (cur == 1) ? ec_b   : ec_a;
    assign s_fe   = (cur == 1) ? fe_b   : fe_a;

    typedef struct {
        int       port;
        logic [7:0] sd;
        int       fl0;
        int       fl1;
        bit       supp;
        int       saddr;
        int       e_err;
        int       e_first;
        bit       e_pass;
        bit       e_tmo;
        int       e_busy;
        int       e_rd;
        int       e_wr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int o_done, o_busy, o_wr, o_rd, o_bad, o_oob, o_overlap, o_pulses, o_extra_busy;
    int o_err, o_first, o_pass, o_tmo, o_first_wr, o_hold_bad;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: every write stores the pattern, so a read differs exactly where the RAM flips it.
    function automatic vec_t model(input int port, input logic [7:0] sd, input bit supp, input int saddr);
        vec_t v;
        int base;
        base = (port == 1) ? 1024 : 0;
        v = '{port, sd, -1, -1, supp, saddr, 0, 0, 1'b0, 1'b0, 3 * DEPTH, DEPTH, DEPTH};
        for (int i = 0; i < DEPTH; i++) begin
            if (supp && base + i == saddr) begin
                v.e_tmo = 1'b1; v.e_first = saddr; v.e_busy = 2 * i + 1 + 15;
                v.e_wr = i + 1; v.e_rd = 0;
                return v;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flip_mask[base + i]) begin
                if (v.e_err == 0) v.e_first = base + i;
                v.e_err++;
            end
        end
        v.e_pass = (v.e_err == 0);
        return v;
    endfunction

    task automatic run_test(input int port, input logic [7:0] sd, input bit supp, input int saddr,
                            input bit pulse_busy);
        int base, cyc;
        base = (port == 1) ? 1024 : 0;
        cur = port; supp_en = supp; supp_addr = 11'(saddr);
        o_done = 0; o_busy = 0; o_wr = 0; o_rd = 0; o_bad = 0; o_oob = 0; o_overlap = 0;
        o_pulses = 0; o_extra_busy = 0; o_first_wr = -1; o_hold_bad = 0;
        @(negedge clk);
        if (port == 1) begin start_b = 1'b1; seed_b = sd; end
        else begin start_a = 1'b1; seed_a = sd; end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        cyc = 0;
        while (o_done == 0 && cyc < LIMIT) begin
            if (pulse_busy) begin
                if (port == 1) start_b = (cyc % 97 == 3); else start_a = (cyc % 97 == 3);
            end
            if (s_busy) o_busy++;
            if (s_wr) begin
                o_wr++;
                if (o_first_wr < 0) o_first_wr = int'(s_addr);
                if (int'(s_dout) != ((int'(s_addr) % 256) ^ int'(sd))) o_bad++;
            end
            if (s_rd) o_rd++;
            if (s_wr && s_rd) o_overlap++;
            if (s_busy && (int'(s_addr) < base || int'(s_addr) > base + DEPTH - 1)) o_oob++;
            if (s_done) begin
                o_done = 1; o_pulses++;
                o_err = int'(s_ec); o_first = int'(s_fe); o_pass = int'(s_pass); o_tmo = int'(s_tmo);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start_a = 1'b0; start_b = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (s_done) o_pulses++;
            if (s_busy) o_extra_busy++;
            if (int'(s_ec) != o_err || int'(s_fe) != o_first || int'(s_pass) != o_pass ||
                int'(s_tmo) != o_tmo) o_hold_bad++;
        end
    endtask

    task automatic check_results(input vec_t v, input string tag);
        int base;
        base = (v.port == 1) ? 1024 : 0;
        check({tag, ".done_seen"}, o_done, 1);
        check({tag, ".busy_cycles"}, o_busy, v.e_busy);
        check({tag, ".writes"}, o_wr, v.e_wr);
        check({tag, ".reads"}, o_rd, v.e_rd);
        check({tag, ".err_count"}, o_err, v.e_err);
        check({tag, ".first_err_addr"}, o_first, v.e_first);
        check({tag, ".pass"}, o_pass, int'(v.e_pass));
        check({tag, ".timeout"}, o_tmo, int'(v.e_tmo));
        check({tag, ".first_write_addr"}, o_first_wr, base);
        check({tag, ".bad_write_data"}, o_bad, 0);
        check({tag, ".addr_out_of_window"}, o_oob, 0);
        check({tag, ".wr_rd_overlap"}, o_overlap, 0);
        check({tag, ".done_pulses"}, o_pulses, 1);
        check({tag, ".busy_after_done"}, o_extra_busy, 0);
        check({tag, ".results_held"}, o_hold_bad, 0);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        flip_mask = '0;
        if (v.fl0 >= 0) flip_mask[v.fl0] = 1'b1;
        if (v.fl1 >= 0) flip_mask[v.fl1] = 1'b1;
        run_test(v.port, v.sd, v.supp, v.saddr, 1'b0);
        check_results(v, tag);
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, ".strobes_flags"}, int'({wr_a, rd_a, busy_a, done_a, pass_a, tmo_a}), 0);
        check({tag, ".mem_addr"}, int'(addr_a), 0);
        check({tag, ".mem_data_out"}, int'(dout_a), 0);
        check({tag, ".err_count"}, int'(ec_a), 0);
        check({tag, ".first_err_addr"}, int'(fe_a), 0);
    endtask

    vec_t vecs[4];

    initial begin
        vec_t v;
        int cyc, strobes, port, nflip, base;
        logic [7:0] sd;
        bit supp;
        int saddr;

        vecs[0] = '{0, 8'hA5, -1, -1, 1'b0, 0, 0, 0, 1'b1, 1'b0, 3072, 1024, 1024};
        vecs[1] = '{0, 8'hA5, 'h010, 'h200, 1'b0, 0, 2, 'h010, 1'b0, 1'b0, 3072, 1024, 1024};
        vecs[2] = '{1, 8'h3C, -1, -1, 1'b0, 0, 0, 0, 1'b1, 1'b0, 3072, 1024, 1024};
        vecs[3] = '{0, 8'h5A, -1, -1, 1'b1, 'h007, 0, 'h007, 1'b0, 1'b1, 30, 0, 8};

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; seed_a = '0; seed_b = '0;
        @(negedge clk);
        @(negedge clk);
        check_zero_a("reset_a");
        check("reset_b.outs", int'({wr_b, rd_b, busy_b, done_b, pass_b, tmo_b, ec_b, fe_b}), 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during the read of 0x100 aborts at once.
        flip_mask = '0; supp_en = 1'b0; cur = 0;
        @(negedge clk);
        start_a = 1'b1; seed_a = 8'h77;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (!(rd_a && addr_a == 11'h100) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("midreset.reached_read_100", int'(rd_a && addr_a == 11'h100), 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero_a("midreset");
        reset = 1'b0;
        strobes = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_a || rd_a || busy_a) strobes++;
        end
        check("midreset.quiet_after", strobes, 0);
        run_test(0, 8'h77, 1'b0, 0, 1'b0);
        check_results(model(0, 8'h77, 1'b0, 0), "after_reset");

        // Starts while busy are ignored; exactly one completion.
        run_test(0, 8'hC3, 1'b0, 0, 1'b1);
        check_results(model(0, 8'hC3, 1'b0, 0), "start_while_busy");

        // Start held high across DONE restarts one cycle after IDLE.
        cur = 0;
        @(negedge clk);
        start_a = 1'b1; seed_a = 8'h11;
        @(negedge clk);
        cyc = 0;
        while (!done_a && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("held.done", int'(done_a), 1);
        check("held.pass", int'(pass_a), 1);
        @(negedge clk);
        check("held.idle_busy", int'(busy_a), 0);
        check("held.idle_done", int'(done_a), 0);
        @(negedge clk);
        check("held.restart_wr", int'(wr_a), 1);
        check("held.restart_addr", int'(addr_a), 0);
        check("held.restart_data", int'(dout_a), 'h11);
        start_a = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Randomised runs against the reference model.
        for (int r = 0; r < 4; r++) begin
            port = int'($urandom_range(0, 1));
            base = (port == 1) ? 1024 : 0;
            sd = 8'($urandom);
            flip_mask = '0;
            nflip = int'($urandom_range(0, 3));
            for (int k = 0; k < nflip; k++) flip_mask[base + int'($urandom_range(0, DEPTH - 1))] = 1'b1;
            supp = ($urandom_range(0, 3) == 0);
            saddr = base + int'($urandom_range(0, DEPTH - 1));
            v = model(port, sd, supp, saddr);
            run_test(port, sd, supp, saddr, 1'b0);
            check_results(v, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
